// File: rtl/load_store_unit.sv
// Data-memory access engine: byte enables, lane-shifted store data, load extension,
// and splitting of word-crossing accesses into two aligned bus beats.
module load_store_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int SPLIT_MISAL = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    // state | meaning
    // IDLE  | ready for a request
    // CHK   | size / alignment check on latched request
    // REQ0  | first bus beat requested, waiting for grant
    // WAIT0 | first beat granted, waiting for rvalid
    // REQ1  | second (split) beat requested
    // WAIT1 | second beat granted, waiting for rvalid
    // RESP  | one-cycle response pulse
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;

    state_t            r_state;
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_beat0;
    logic [XLEN-1:0]   r_beat1;

    logic [OFS-1:0]    w_off;
    logic [3:0]        w_bytes;
    logic [4:0]        w_end;
    logic              w_split;
    logic              w_illegal;
    logic [OFS-1:0]    w_align_mask;
    logic              w_misal;
    logic [2*NB-1:0]   w_mask;
    logic [2*NB-1:0]   w_be_full;
    logic [2*XLEN-1:0] w_wd_full;
    logic [ADDR_W-1:0] w_base;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_ld;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    assign w_off        = r_addr[OFS-1:0];
    assign w_bytes      = 4'd1 << r_size;
    assign w_end        = 5'(w_off) + 5'(w_bytes);
    assign w_split      = w_end > 5'(NB);
    assign w_illegal    = int'(r_size) > OFS;
    assign w_align_mask = OFS'(w_bytes - 4'd1);
    assign w_misal      = |(w_off & w_align_mask);
    assign w_mask       = (2*NB)'((16'd1 << w_bytes) - 16'd1);
    assign w_be_full    = w_mask << w_off;
    assign w_wd_full    = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_base       = r_addr & ~ADDR_W'(NB - 1);

    // The beat arriving this cycle bypasses its capture register so the response can register now.
    assign w_lo = (r_state == S_WAIT0) ? i_mem_rdata : r_beat0;
    assign w_hi = (r_state == S_WAIT1) ? i_mem_rdata : r_beat1;
    assign w_ld = XLEN'({w_hi, w_lo} >> {w_off, 3'b000});

    always_comb begin
        case (r_size)
            2'd0:    w_sign = w_ld[7];
            2'd1:    w_sign = w_ld[15];
            2'd2:    w_sign = w_ld[31];
            default: w_sign = w_ld[XLEN-1];
        endcase
        w_ext = w_ld;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= 8 * int'(w_bytes)) w_ext[i] = w_sign & ~r_unsigned;
        end
    end

    assign o_req_ready = (r_state == S_IDLE) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beat0     <= '0;
            r_beat1     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write    <= i_req_write;
                        r_unsigned <= i_req_unsigned;
                        r_size     <= i_req_size;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_state    <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (w_illegal || (SPLIT_MISAL == 0 && w_misal)) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_beat1     <= '0;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= r_write;
                        o_mem_addr  <= w_base;
                        o_mem_be    <= w_be_full[NB-1:0];
                        o_mem_wdata <= w_wd_full[XLEN-1:0];
                        r_state     <= S_REQ0;
                    end
                end
                S_REQ0: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        r_state   <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (i_mem_rvalid) begin
                        r_beat0 <= i_mem_rdata;
                        if (w_split) begin
                            o_mem_req   <= 1'b1;
                            o_mem_addr  <= w_base + ADDR_W'(NB);
                            o_mem_be    <= w_be_full[2*NB-1:NB];
                            o_mem_wdata <= w_wd_full[2*XLEN-1:XLEN];
                            r_state     <= S_REQ1;
                        end else begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= 1'b0;
                            o_rsp_rdata <= r_write ? '0 : w_ext;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        r_state   <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (i_mem_rvalid) begin
                        r_beat1     <= i_mem_rdata;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_rdata <= r_write ? '0 : w_ext;
                        r_state     <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
